// File: rtl/core_pkg.sv
// core_pkg: shared widths, ALU opcodes and pipeline bundle types for the RV32I core
package core_pkg;
  localparam int XLEN = 32;
  localparam int ALU_OP_W = 4;
  localparam int CNT_W = 16;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;
  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t NOP_CTRL = '0;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
  } id_ex_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection, flush and stall handling
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int CNT_W = core_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic                id_branch,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                ex_flush,
  input  logic                mem_stall,
  output logic                ID_EX_Valid,
  output logic [XLEN-1:0]     ID_EX_Pc,
  output logic [4:0]          ID_EX_Rs1,
  output logic [4:0]          ID_EX_Rs2,
  output logic [4:0]          ID_EX_Rd,
  output logic                ID_EX_UsesRs1,
  output logic                ID_EX_UsesRs2,
  output logic [XLEN-1:0]     ID_EX_Rs1Data,
  output logic [XLEN-1:0]     ID_EX_Rs2Data,
  output logic [XLEN-1:0]     ID_EX_Imm,
  output logic                ID_EX_RegWrite,
  output logic                ID_EX_MemRead,
  output logic                ID_EX_MemWrite,
  output logic                ID_EX_MemToReg,
  output logic                ID_EX_AluSrc,
  output logic                ID_EX_Branch,
  output logic [ALU_OP_W-1:0] ID_EX_AluOp,
  output logic                pc_write_en,
  output logic                if_id_write_en,
  output logic                load_use_stall,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  id_ex_t q, d;
  logic bubble;
  always_comb begin
    d = '{valid: id_valid, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
          uses_rs1: id_uses_rs1, uses_rs2: id_uses_rs2, rs1_data: id_rs1_data,
          rs2_data: id_rs2_data, imm: id_imm, ctrl: NOP_CTRL};
    d.ctrl = id_valid ? '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                          mem_to_reg: id_mem_to_reg, alu_src: id_alu_src, branch: id_branch,
                          alu_op: id_alu_op} : NOP_CTRL;
  end
  assign load_use_stall = id_valid & q.valid & q.ctrl.mem_read & (|q.rd) & ~ex_flush &
                          ((id_uses_rs1 & (id_rs1 == q.rd)) | (id_uses_rs2 & (id_rs2 == q.rd)));
  // A flush masks the hazard, so front-end enables only depend on stall conditions
  assign pc_write_en    = ~mem_stall & ~load_use_stall;
  assign if_id_write_en = pc_write_en;
  assign bubble         = ex_flush | load_use_stall | ~id_valid;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (!mem_stall) q <= bubble ? '0 : d;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(~mem_stall & load_use_stall), .q(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(~mem_stall & ex_flush), .q(flush_cnt));
  assign ID_EX_Valid    = q.valid;
  assign ID_EX_Pc       = q.pc;
  assign ID_EX_Rs1      = q.rs1;
  assign ID_EX_Rs2      = q.rs2;
  assign ID_EX_Rd       = q.rd;
  assign ID_EX_UsesRs1  = q.uses_rs1;
  assign ID_EX_UsesRs2  = q.uses_rs2;
  assign ID_EX_Rs1Data  = q.rs1_data;
  assign ID_EX_Rs2Data  = q.rs2_data;
  assign ID_EX_Imm      = q.imm;
  assign ID_EX_RegWrite = q.ctrl.reg_write;
  assign ID_EX_MemRead  = q.ctrl.mem_read;
  assign ID_EX_MemWrite = q.ctrl.mem_write;
  assign ID_EX_MemToReg = q.ctrl.mem_to_reg;
  assign ID_EX_AluSrc   = q.ctrl.alu_src;
  assign ID_EX_Branch   = q.ctrl.branch;
  assign ID_EX_AluOp    = q.ctrl.alu_op;
endmodule
